// File: rtl/wb_trace_pkg.sv
// ---------------------------------------------------------------------------
// wb_trace_pkg
// Shared constants and helpers for the write-back trace buffer.
//   WB_DATA_W  : width of the CPU write-back value being traced
//   WB_TS_W    : width of the free-running cycle timestamp
//   WB_DROP_W  : width of the saturating dropped-capture counter
//   WB_ENTRY_W : width of one stored entry {timestamp, data}
// fifo_op_e names the four push/pop combinations the FIFO can see in a cycle.
// sat_inc is the saturating increment used for the drop counter.
// ---------------------------------------------------------------------------
package wb_trace_pkg;

    localparam int WB_DATA_W  = 32;
    localparam int WB_TS_W    = 16;
    localparam int WB_DROP_W  = 16;
    localparam int WB_ENTRY_W = WB_DATA_W + WB_TS_W;

    typedef enum logic [1:0] {
        FIFO_IDLE = 2'b00,
        FIFO_PUSH = 2'b01,
        FIFO_POP  = 2'b10,
        FIFO_BOTH = 2'b11
    } fifo_op_e;

    // Counter sticks at all-ones so a long overflow burst never wraps to a
    // misleadingly small value.
    function automatic logic [WB_DROP_W-1:0] sat_inc(input logic [WB_DROP_W-1:0] value);
        return (value == '1) ? value : value + WB_DROP_W'(1);
    endfunction

endpackage

// File: rtl/wb_trace_buffer_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock circular FIFO with show-ahead head output.
//   i_clk       : clock, rising edge
//   i_rst       : synchronous active-high reset (empties the FIFO)
//   i_push      : write i_push_data at the tail
//   i_push_data : entry to write
//   i_pop       : remove the head entry
//   o_head_data : current head entry, zero while empty
//   o_level     : number of entries held (0..DEPTH)
//   o_full      : level == DEPTH
//   o_empty     : level == 0
// A push while full is accepted only when a pop happens in the same cycle.
// ---------------------------------------------------------------------------
module sync_fifo
    import wb_trace_pkg::*;
#(
    parameter int WIDTH = WB_ENTRY_W,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_data,
    output logic [LW-1:0]    o_level,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;

    logic             w_full;
    logic             w_empty;
    logic             w_do_push;
    logic             w_do_pop;
    fifo_op_e         w_op;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == LW'(DEPTH));

    // A pop frees the slot the simultaneous push needs, so full+pop+push is
    // a legal steady-state transfer.
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);
    assign w_op      = fifo_op_e'({w_do_pop, w_do_push});

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH by
    // themselves; the level counter is what tells full from empty.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case (w_op)
                FIFO_PUSH: r_level <= r_level + LW'(1);
                FIFO_POP:  r_level <= r_level - LW'(1);
                default:   r_level <= r_level;
            endcase
        end
    end

    // Storage carries no reset; stale words are never visible because the
    // head output is forced to zero while the FIFO is empty.
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_head_data = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_level     = r_level;
    assign o_full      = w_full;
    assign o_empty     = w_empty;

endmodule

// File: rtl/wb_trace_buffer.sv
// ---------------------------------------------------------------------------
// wb_trace_buffer
// Watches the CPU write-back debug bus and records every change of value,
// tagged with a cycle timestamp, into a FIFO that a consumer drains through
// a valid/ready port. The CPU is never stalled: captures that find the FIFO
// full are dropped and counted instead.
//   i_clk        : clock, rising edge
//   i_rst        : synchronous active-high reset
//   i_wb_data    : CPU write-back value
//   i_capture_en : capture enable; while low nothing is sampled
//   o_out_valid  : head entry available
//   i_out_ready  : consumer accepts the head entry
//   o_out_data   : head entry data (show-ahead)
//   o_out_ts     : head entry timestamp (show-ahead)
//   o_level      : entries held
//   o_overflow   : sticky, set once any capture was dropped
//   o_drop_cnt   : number of dropped captures, saturating
// ---------------------------------------------------------------------------
module wb_trace_buffer
    import wb_trace_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int TS_W   = WB_TS_W,
    parameter int DEPTH  = 16,
    localparam int LW    = $clog2(DEPTH) + 1,
    localparam int EW    = DATA_W + TS_W
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [DATA_W-1:0]    i_wb_data,
    input  logic                 i_capture_en,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [DATA_W-1:0]    o_out_data,
    output logic [TS_W-1:0]      o_out_ts,
    output logic [LW-1:0]        o_level,
    output logic                 o_overflow,
    output logic [WB_DROP_W-1:0] o_drop_cnt
);

    logic [TS_W-1:0]      r_ts;
    logic [DATA_W-1:0]    r_prev;
    logic                 r_primed;
    logic                 r_overflow;
    logic [WB_DROP_W-1:0] r_drop_cnt;

    logic                 w_capture;
    logic                 w_pop;
    logic                 w_drop;
    logic                 w_push;
    logic                 w_full;
    logic                 w_empty;
    logic [EW-1:0]        w_head;
    logic [LW-1:0]        w_level;

    // The first enabled sample after reset is always recorded, even if it
    // happens to equal the reset value of r_prev.
    assign w_capture = i_capture_en && (!r_primed || (i_wb_data != r_prev));

    // out_valid comes straight from the registered level, so the pop
    // decision never loops back through out_ready into out_valid.
    assign w_pop  = !w_empty && i_out_ready;
    assign w_drop = w_capture && w_full && !w_pop;
    assign w_push = w_capture && !w_drop;

    // Timestamp, change detector and drop bookkeeping. r_prev follows the
    // bus even for dropped captures so a dropped value is not re-captured
    // on the next cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ts       <= '0;
            r_prev     <= '0;
            r_primed   <= 1'b0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_ts <= r_ts + TS_W'(1);
            if (w_capture) begin
                r_prev   <= i_wb_data;
                r_primed <= 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                r_drop_cnt <= sat_inc(r_drop_cnt);
            end
        end
    end

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (w_push),
        .i_push_data ({r_ts, i_wb_data}),
        .i_pop       (w_pop),
        .o_head_data (w_head),
        .o_level     (w_level),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    assign o_out_valid = !w_empty;
    assign o_out_data  = w_head[DATA_W-1:0];
    assign o_out_ts    = w_head[DATA_W +: TS_W];
    assign o_level     = w_level;
    assign o_overflow  = r_overflow;
    assign o_drop_cnt  = r_drop_cnt;

endmodule

// File: doc/wb_trace_buffer.md
# wb_trace_buffer

Downstream consumer of the single-cycle CPU's write-back debug bus. Samples `debug_WriteBackData` every cycle, records each new value with a cycle timestamp into a circular FIFO, and drains entries through a valid/ready port to a bench checker or a later UART/trace exporter. Overflow is counted, never stalls the CPU.

## Interface
- `DATA_W`, 32, write-back data width
- `TS_W`, 16, timestamp (cycle counter) width
- `DEPTH`, 16, FIFO entries; power of two, ≥2
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `wb_data`  in  DATA_W  CPU write-back value (`debug_WriteBackData`)
- `capture_en`  in  1  capture enable; 0 = sample nothing, prev/primed untouched
- `out_valid`  out  1  head entry available
- `out_ready`  in  1  consumer accepts head
- `out_data`  out  DATA_W  head entry data
- `out_ts`  out  TS_W  head entry timestamp
- `level`  out  $clog2(DEPTH)+1  entries held
- `overflow`  out  1  sticky: at least one capture dropped
- `drop_cnt`  out  16  dropped captures, saturating at 16'hFFFF

## Operation
- Cycle counter `ts`: 0 while `rst`=1; +1 on every edge with `rst`=0; wraps modulo 2^TS_W.
- Capture condition at an edge: `capture_en`=1 and (`primed`=0 or `wb_data`≠`prev`).
- On capture condition: `prev`←`wb_data`, `primed`←1, push {`ts` pre-increment value, `wb_data`}.
- First enabled cycle after reset always captures (including value 0).
- Pop: `out_valid`&&`out_ready` at an edge removes head.
- Full (`level`=DEPTH) and capture, no pop: entry dropped, `overflow`←1, `drop_cnt`+1 (saturate); `prev` still updates.
- Full with simultaneous pop and capture: push accepted, `level` stays DEPTH, no drop.
- Empty with capture: entry pushed; pop not possible same cycle (`out_valid`=0).
- Pointers wrap modulo DEPTH; `level` distinguishes full from empty.
- Reset values: `out_valid`=0, `out_data`=0, `out_ts`=0, `level`=0, `overflow`=0, `drop_cnt`=0, `primed`=0, `prev`=0, pointers=0.
- Reset mid-operation: all contents discarded, no further output until new captures.

## Timing
- Capture→visible latency 1: value stable before edge N is written at N; `out_valid`=1 after N.
- `out_data`/`out_ts` are show-ahead: reflect head combinationally from storage; stable while `out_valid`=1 and `out_ready`=0.
- Throughput: one push and one pop per cycle.
- `out_valid` does not depend combinationally on `out_ready`; `out_ready` may toggle freely.
- `level`, `overflow`, `drop_cnt` registered, update at the same edge as the push/pop/drop causing them.

## Structure
- Shared `wb_trace_pkg`: `WB_DATA_W`=32, `WB_TS_W`=16, `WB_DROP_W`=16, entry width constant `WB_ENTRY_W`=DATA_W+TS_W.
- Sub-module `sync_fifo` (parameterised width/depth, show-ahead, push/pop/level/full/empty); top holds timestamp counter, change detector, drop/overflow logic.
- Single `clk` domain, no latches, no asynchronous reset.

## Test plan
- Reset release, `capture_en`=1, `wb_data` held 0x00000005 for 10 cycles, `out_ready`=0 → exactly one entry {ts=0, 0x00000005}; `level`=1.
- Sequence 0x1, 0x1, 0x2, 0x3, 0x3 on consecutive cycles, `out_ready`=1 → three pops: (0,0x1), (2,0x2), (3,0x3) in order, `drop_cnt`=0.
- `out_ready`=0, 20 distinct values with DEPTH=16 → `level`=16, `overflow`=1, `drop_cnt`=4; draining yields first 16 values in order.
- Full FIFO, same cycle capture 0xABCD and `out_ready`=1 → `level` stays 16, `drop_cnt` unchanged, 0xABCD drained last.
- `capture_en`=0 while `wb_data` changes 0x7→0x8, then enable with 0x8 held → one entry 0x8 (first capture since primed=0).
- Assert `rst` for one cycle with `level`=5 → next cycle `level`=0, `out_valid`=0, `overflow`=0, `ts` restarts at 0.
